// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter slice: FSM state encodings,
// requester ids and datapath widths. ALU op / src2 encodings belong to the
// decoder and are only carried through here as opaque fields.
package alu_arbiter_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 3;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic REQ_ISSUE  = 1'b0;
  localparam logic REQ_BRANCH = 1'b1;

endpackage

// File: rtl/alu_arbiter_pick.sv
// Combinational winner selection between the issue (0) and branch (1)
// requesters. On a tie the pointer names the winner; a lone valid always
// wins. The grant is one-hot and all-zero when nobody is requesting.
module alu_arbiter_pick
  import alu_arbiter_pkg::*;
(
  input  logic       i_valid0,
  input  logic       i_valid1,
  input  logic       i_ptr,
  output logic [1:0] o_grant,
  output logic       o_winner
);

  // Resolve the winner and build the one-hot grant
  always_comb begin
    o_winner = REQ_ISSUE;
    o_grant  = '0;
    if (i_valid0 && i_valid1) begin
      o_winner = i_ptr;
    end else if (i_valid1) begin
      o_winner = REQ_BRANCH;
    end
    if (i_valid0 || i_valid1) begin
      o_grant[o_winner] = 1'b1;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Sequencer/arbiter sharing one combinational Executor ALU between the
// issue stage (requester 0) and the branch/address unit (requester 1).
// Flow per operation: IDLE (grant) -> EXEC (ALU evaluates) -> RESP (hold
// result until the owner accepts it).
// Build option: define ALU_ARBITER_RR_EN for round-robin tie breaking;
// otherwise requester 0 always wins a tie and no pointer register exists.
module alu_arbiter
  import alu_arbiter_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req0_valid,
  output logic              o_req0_ready,
  input  logic [DATA_W-1:0] i_req0_rs1,
  input  logic [DATA_W-1:0] i_req0_rs2,
  input  logic [DATA_W-1:0] i_req0_imm,
  input  logic              i_req0_src2,
  input  logic [OP_W-1:0]   i_req0_op,
  input  logic              i_req1_valid,
  output logic              o_req1_ready,
  input  logic [DATA_W-1:0] i_req1_rs1,
  input  logic [DATA_W-1:0] i_req1_rs2,
  input  logic [DATA_W-1:0] i_req1_imm,
  input  logic              i_req1_src2,
  input  logic [OP_W-1:0]   i_req1_op,
  output logic              o_rsp0_valid,
  input  logic              i_rsp0_ready,
  output logic              o_rsp1_valid,
  input  logic              i_rsp1_ready,
  output logic [DATA_W-1:0] o_rsp_res,
  output logic [DATA_W-1:0] o_alu_rs1,
  output logic [DATA_W-1:0] o_alu_rs2,
  output logic [DATA_W-1:0] o_alu_imm,
  output logic              o_alu_src2,
  output logic [OP_W-1:0]   o_alu_op,
  input  logic [DATA_W-1:0] i_alu_res
);

  logic [1:0]        r_state;
  logic              r_owner;
  logic [DATA_W-1:0] r_rsp_res;
  logic [DATA_W-1:0] r_alu_rs1;
  logic [DATA_W-1:0] r_alu_rs2;
  logic [DATA_W-1:0] r_alu_imm;
  logic              r_alu_src2;
  logic [OP_W-1:0]   r_alu_op;

  logic              w_ptr;
  logic [1:0]        w_grant;
  logic              w_winner;
  logic [1:0]        w_ready;
  logic              w_accept;
  logic              w_owner_rsp_ready;

`ifdef ALU_ARBITER_RR_EN
  logic r_ptr;

  // Tie-break pointer: after each accepted request, favour the loser
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ptr <= REQ_ISSUE;
    end else if (w_accept) begin
      r_ptr <= ~w_winner;
    end
  end

  assign w_ptr = r_ptr;
`else
  assign w_ptr = REQ_ISSUE;
`endif

  alu_arbiter_pick u_pick (
    .i_valid0 (i_req0_valid),
    .i_valid1 (i_req1_valid),
    .i_ptr    (w_ptr),
    .o_grant  (w_grant),
    .o_winner (w_winner)
  );

  assign w_ready           = (r_state == IDLE) ? w_grant : 2'b00;
  assign w_accept          = |w_ready;
  assign w_owner_rsp_ready = (r_owner == REQ_BRANCH) ? i_rsp1_ready : i_rsp0_ready;

  // Sequence IDLE -> EXEC -> RESP and hold operands/result registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_owner    <= REQ_ISSUE;
      r_rsp_res  <= '0;
      r_alu_rs1  <= '0;
      r_alu_rs2  <= '0;
      r_alu_imm  <= '0;
      r_alu_src2 <= 1'b0;
      r_alu_op   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state <= EXEC;
            r_owner <= w_winner;
            if (w_winner == REQ_BRANCH) begin
              r_alu_rs1  <= i_req1_rs1;
              r_alu_rs2  <= i_req1_rs2;
              r_alu_imm  <= i_req1_imm;
              r_alu_src2 <= i_req1_src2;
              r_alu_op   <= i_req1_op;
            end else begin
              r_alu_rs1  <= i_req0_rs1;
              r_alu_rs2  <= i_req0_rs2;
              r_alu_imm  <= i_req0_imm;
              r_alu_src2 <= i_req0_src2;
              r_alu_op   <= i_req0_op;
            end
          end
        end
        EXEC: begin
          r_rsp_res <= i_alu_res;
          r_state   <= RESP;
        end
        RESP: begin
          if (w_owner_rsp_ready) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_req0_ready = w_ready[0];
  assign o_req1_ready = w_ready[1];
  assign o_rsp0_valid = (r_state == RESP) && (r_owner == REQ_ISSUE);
  assign o_rsp1_valid = (r_state == RESP) && (r_owner == REQ_BRANCH);
  assign o_rsp_res    = r_rsp_res;
  assign o_alu_rs1    = r_alu_rs1;
  assign o_alu_rs2    = r_alu_rs2;
  assign o_alu_imm    = r_alu_imm;
  assign o_alu_src2   = r_alu_src2;
  assign o_alu_op     = r_alu_op;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter. A behavioural Executor stub answers
// the registered ALU operands; expectations come from the issued request
// payloads and a transaction-level arbitration model.
module tb_alu_arbiter;

  // Decoder encodings as seen by the Executor stub
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_BEQ = 3'd2;
  localparam logic [2:0] OP_BNE = 3'd3;
  localparam logic       SRC_REG = 1'b0;
  localparam logic       SRC_IMM = 1'b1;

  logic        clk;
  logic        rst;
  logic        req_valid [2];
  logic [31:0] req_rs1   [2];
  logic [31:0] req_rs2   [2];
  logic [31:0] req_imm   [2];
  logic        req_src2  [2];
  logic [2:0]  req_op    [2];
  logic [1:0]  rsp_ready;

  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [31:0] rsp_res, alu_rs1, alu_rs2, alu_imm, alu_res;
  logic        alu_src2;
  logic [2:0]  alu_op;

  logic [1:0]  rdy;
  logic [1:0]  rspv;
  assign rdy  = {req1_ready, req0_ready};
  assign rspv = {rsp1_valid, rsp0_valid};

  int vectors = 0;
  int errors  = 0;

  function automatic logic [31:0] exec_ref(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_BEQ:  return {31'd0, a == b};
      OP_BNE:  return {31'd0, a != b};
      default: return a ^ b;
    endcase
  endfunction

  assign alu_res = exec_ref(alu_op, alu_rs1, alu_src2 ? alu_imm : alu_rs2);

  alu_arbiter dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req0_valid (req_valid[0]),
    .o_req0_ready (req0_ready),
    .i_req0_rs1   (req_rs1[0]),
    .i_req0_rs2   (req_rs2[0]),
    .i_req0_imm   (req_imm[0]),
    .i_req0_src2  (req_src2[0]),
    .i_req0_op    (req_op[0]),
    .i_req1_valid (req_valid[1]),
    .o_req1_ready (req1_ready),
    .i_req1_rs1   (req_rs1[1]),
    .i_req1_rs2   (req_rs2[1]),
    .i_req1_imm   (req_imm[1]),
    .i_req1_src2  (req_src2[1]),
    .i_req1_op    (req_op[1]),
    .o_rsp0_valid (rsp0_valid),
    .i_rsp0_ready (rsp_ready[0]),
    .o_rsp1_valid (rsp1_valid),
    .i_rsp1_ready (rsp_ready[1]),
    .o_rsp_res    (rsp_res),
    .o_alu_rs1    (alu_rs1),
    .o_alu_rs2    (alu_rs2),
    .o_alu_imm    (alu_imm),
    .o_alu_src2   (alu_src2),
    .o_alu_op     (alu_op),
    .i_alu_res    (alu_res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_req(input int r, input logic [2:0] op, input logic [31:0] rs1,
                         input logic [31:0] rs2, input logic [31:0] imm, input logic src2);
    req_op[r] = op; req_rs1[r] = rs1; req_rs2[r] = rs2; req_imm[r] = imm; req_src2[r] = src2;
  endtask

  task automatic rand_req(input int r);
    set_req(r, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)));
  endtask

  // One full transaction on requester r; response accepted after `hold` extra cycles.
  // Entered at a negedge (or just after one); returns at a negedge in IDLE.
  task automatic run_op(input int r, input logic [2:0] op, input logic [31:0] rs1,
                        input logic [31:0] rs2, input logic [31:0] imm, input logic src2,
                        input int hold, input logic [31:0] exp, output int waited);
    logic [1:0] oh;
    oh = (r == 1) ? 2'b10 : 2'b01;
    set_req(r, op, rs1, rs2, imm, src2);
    req_valid[r] = 1'b1;
    rsp_ready = 2'b00;
    #1;
    waited = 0;
    while (rdy !== oh && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    vectors++;
    if (rdy !== oh) begin
      errors++;
      $display("FAIL grant req%0d: ready=%b required=%b (timeout)", r, rdy, oh);
      req_valid[r] = 1'b0;
      return;
    end
    @(posedge clk); #1;
    req_valid[r] = 1'b0;
    @(negedge clk);
    vectors++;
    if ({alu_rs1, alu_rs2, alu_imm, alu_src2, alu_op, rspv, rdy} !==
        {rs1, rs2, imm, src2, op, 2'b00, 2'b00}) begin
      errors++;
      $display("FAIL exec_regs req%0d: rs1=%h rs2=%h imm=%h src2=%b op=%0d rspv=%b rdy=%b required %h %h %h %b %0d 00 00",
               r, alu_rs1, alu_rs2, alu_imm, alu_src2, alu_op, rspv, rdy, rs1, rs2, imm, src2, op);
    end
    for (int h = 0; h <= hold; h++) begin
      @(negedge clk);
      vectors++;
      if (rspv !== oh || rsp_res !== exp || rdy !== 2'b00) begin
        errors++;
        $display("FAIL resp req%0d cyc%0d: rspv=%b res=%h rdy=%b required %b %h 00",
                 r, h, rspv, rsp_res, rdy, oh, exp);
      end
      if (h == hold) rsp_ready[r] = 1'b1;
    end
    @(negedge clk);
    rsp_ready = 2'b00;
    vectors++;
    if (rspv !== 2'b00) begin
      errors++;
      $display("FAIL resp_release req%0d: rspv=%b required 00", r, rspv);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid[0] = 1'b0; req_valid[1] = 1'b0;
    rsp_ready = 2'b00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int r = 0; r < 2; r++) begin
      req_valid[r] = 1'b0;
      set_req(r, 3'd0, '0, '0, '0, 1'b0);
    end
    rsp_ready = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({rdy, rspv, rsp_res, alu_rs1, alu_rs2, alu_imm, alu_src2, alu_op} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: rdy=%b rspv=%b res=%h rs1=%h rs2=%h imm=%h src2=%b op=%0d required all 0",
               rdy, rspv, rsp_res, alu_rs1, alu_rs2, alu_imm, alu_src2, alu_op);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single();
    int w;
    run_op(0, OP_ADD, 32'd5, 32'd7, 32'd0, SRC_REG, 0, 32'd12, w);
    vectors++;
    if (w !== 0) begin
      errors++;
      $display("FAIL single_first_cycle_ready: waited=%0d required=0", w);
    end
  endtask

  task automatic test_imm();
    int w;
    run_op(1, OP_SUB, 32'd100, 32'h0000FFFF, 32'd30, SRC_IMM, 0, 32'd70, w);
  endtask

  task automatic test_tie();
    logic       ptr_m;
    logic       exp_w;
    logic [1:0] exp_oh;
    logic [31:0] exp_res;
    do_reset();
    ptr_m = 1'b0;
    rand_req(0); rand_req(1);
    req_valid[0] = 1'b1; req_valid[1] = 1'b1;
    rsp_ready = 2'b11;
    #1;
    for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARBITER_RR_EN
      exp_w = ptr_m;
`else
      exp_w = 1'b0;
`endif
      exp_oh = exp_w ? 2'b10 : 2'b01;
      exp_res = exec_ref(req_op[exp_w], req_rs1[exp_w],
                         req_src2[exp_w] ? req_imm[exp_w] : req_rs2[exp_w]);
      vectors++;
      if (rdy !== exp_oh) begin
        errors++;
        $display("FAIL tie_grant%0d: ready=%b required=%b", i, rdy, exp_oh);
      end
      @(posedge clk); #1;
      rand_req(exp_w);
      ptr_m = ~exp_w;
      @(negedge clk);
      vectors++;
      if (rdy !== 2'b00) begin
        errors++;
        $display("FAIL tie_exec_wait%0d: ready=%b required=00", i, rdy);
      end
      @(negedge clk);
      vectors++;
      if (rspv !== exp_oh || rsp_res !== exp_res) begin
        errors++;
        $display("FAIL tie_resp%0d: rspv=%b res=%h required %b %h", i, rspv, rsp_res, exp_oh, exp_res);
      end
      @(negedge clk);
    end
    req_valid[0] = 1'b0; req_valid[1] = 1'b0;
    rsp_ready = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_back_pressure();
    logic [31:0] exp1;
    set_req(0, OP_BEQ, 32'd9, 32'd9, $urandom, SRC_REG);
    req_valid[0] = 1'b1;
    rsp_ready = 2'b00;
    #1;
    vectors++;
    if (rdy !== 2'b01) begin
      errors++;
      $display("FAIL bp_grant0: ready=%b required=01", rdy);
    end
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    set_req(1, OP_ADD, $urandom, $urandom, $urandom, SRC_REG);
    exp1 = req_rs1[1] + req_rs2[1];
    req_valid[1] = 1'b1;
    rsp_ready[1] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++;
      if (rdy !== 2'b00 || (i > 0 && (rspv !== 2'b01 || rsp_res !== 32'd1))) begin
        errors++;
        $display("FAIL bp_hold%0d: ready=%b rspv=%b res=%h required 00 01 1", i, rdy, rspv, rsp_res);
      end
    end
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    rsp_ready[0] = 1'b0;
    vectors++;
    if (rdy !== 2'b10 || rspv !== 2'b00) begin
      errors++;
      $display("FAIL bp_next_grant: ready=%b rspv=%b required 10 00", rdy, rspv);
    end
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (rspv !== 2'b10 || rsp_res !== exp1) begin
      errors++;
      $display("FAIL bp_req1_resp: rspv=%b res=%h required 10 %h", rspv, rsp_res, exp1);
    end
    @(negedge clk);
    rsp_ready = 2'b00;
  endtask

  task automatic test_bne();
    int w;
    run_op(0, OP_BNE, 32'd3, 32'd3, 32'd0, SRC_REG, 1, 32'd0, w);
    run_op(1, OP_BNE, 32'd3, 32'd4, 32'd0, SRC_REG, 0, 32'd1, w);
  endtask

  task automatic test_reset_exec();
    int w;
    set_req(0, OP_ADD, 32'h1234, 32'h1111, 32'h77, SRC_IMM);
    req_valid[0] = 1'b1;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if ({rdy, rspv, rsp_res, alu_rs1, alu_rs2, alu_imm, alu_src2, alu_op} !== '0) begin
      errors++;
      $display("FAIL reset_in_exec: rdy=%b rspv=%b res=%h rs1=%h rs2=%h imm=%h src2=%b op=%0d required all 0",
               rdy, rspv, rsp_res, alu_rs1, alu_rs2, alu_imm, alu_src2, alu_op);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (rspv !== 2'b00) begin
      errors++;
      $display("FAIL reset_drop: rspv=%b required 00", rspv);
    end
    run_op(1, OP_ADD, 32'd40, 32'd2, 32'd0, SRC_REG, 0, 32'd42, w);
  endtask

  task automatic test_random();
    int          w;
    int          r;
    logic [2:0]  op;
    logic [31:0] a, b, im;
    logic        s;
    for (int i = 0; i < 24; i++) begin
      r  = int'($urandom_range(0, 1));
      op = 3'($urandom_range(0, 7));
      a  = $urandom; b = $urandom; im = $urandom;
      s  = 1'($urandom_range(0, 1));
      if (op == OP_BEQ || op == OP_BNE) begin
        if ($urandom_range(0, 1) == 0) b = a;
      end
      run_op(r, op, a, b, im, s, int'($urandom_range(0, 3)), exec_ref(op, a, s ? im : b), w);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_imm();
    test_tie();
    test_back_pressure();
    test_bne();
    test_reset_exec();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
